gcd_stein_engine: RTL

- Parametrised iterative binary (Stein) GCD engine; successor to the fixed 32-bit gcd_calculator.
- Generic WIDTH operands.
- Valid/ready handshake on both input and result.
- Explicit zero-operand handling, synchronous abort, optional per-result cycle count.
- Sits between operand producers (CPU/regfile glue) and result consumers; one operation in flight.

---
 rtl/gcd_stein_engine.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/gcd_stein_engine.sv
// Iterative binary (Stein) GCD engine with valid/ready handshakes, zero-operand
// shortcut and synchronous abort. Define GCD_CYCLE_CNT_EN to add the cycles port.
module gcd_stein_engine #(
  parameter int WIDTH = 32,
  parameter int KW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] gcd,
  output logic             zero_flag
`ifdef GCD_CYCLE_CNT_EN
  ,
  output logic [KW+$clog2(WIDTH)+2-1:0] cycles
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [KW-1:0]    r_k;
  logic [WIDTH-1:0] r_gcd;
  logic             r_zero;

  logic             w_accept;
  logic             w_x_zero;
  logic             w_y_zero;
  logic             w_any_zero;
  logic             w_eq;
  logic             w_a_even;
  logic             w_b_even;
  logic             w_a_gt_b;
  logic [WIDTH-1:0] w_diff_ab;
  logic [WIDTH-1:0] w_diff_ba;
  logic [WIDTH-1:0] w_result;

  assign w_accept   = in_valid && in_ready;
  assign w_x_zero   = (x == '0);
  assign w_y_zero   = (y == '0);
  assign w_any_zero = w_x_zero || w_y_zero;

  assign w_eq      = (r_a == r_b);
  assign w_a_even  = ~r_a[0];
  assign w_b_even  = ~r_b[0];
  assign w_a_gt_b  = (r_a > r_b);
  // Both differences exist, but only the larger-minus-smaller one is ever selected.
  assign w_diff_ab = r_a - r_b;
  assign w_diff_ba = r_b - r_a;
  assign w_result  = r_a << r_k;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; clear overrides every handshake
  always_comb begin
    w_state_next = r_state;
    if (clear) begin
      w_state_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            w_state_next = w_any_zero ? S_DONE : S_CALC;
          end
        end
        S_CALC: begin
          if (w_eq) begin
            w_state_next = S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            w_state_next = S_IDLE;
          end
        end
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  // Output decode
  always_comb begin
    in_ready  = (r_state == S_IDLE) && !clear;
    out_valid = (r_state == S_DONE);
  end

  // Operand / result datapath
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_a    <= '0;
      r_b    <= '0;
      r_k    <= '0;
      r_gcd  <= '0;
      r_zero <= 1'b0;
    end else if (!clear) begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_a    <= x;
            r_b    <= y;
            r_k    <= '0;
            r_zero <= w_x_zero && w_y_zero;
            if (w_any_zero) begin
              r_gcd <= x | y;
            end
          end
        end
        S_CALC: begin
          if (w_eq) begin
            r_gcd <= w_result;
          end else if (w_a_even && w_b_even) begin
            r_a <= r_a >> 1;
            r_b <= r_b >> 1;
            r_k <= r_k + KW'(1);
          end else if (w_a_even) begin
            r_a <= r_a >> 1;
          end else if (w_b_even) begin
            r_b <= r_b >> 1;
          end else if (w_a_gt_b) begin
            r_a <= w_diff_ab >> 1;
          end else begin
            r_b <= w_diff_ba >> 1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign gcd       = r_gcd;
  assign zero_flag = r_zero;

`ifdef GCD_CYCLE_CNT_EN
  localparam int CW = KW + $clog2(WIDTH) + 2;

  logic [CW-1:0] r_cycles;

  // Counts every CALC cycle including the terminating a==b one; held through DONE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cycles <= '0;
    end else if (!clear) begin
      if (w_accept) begin
        r_cycles <= '0;
      end else if (r_state == S_CALC) begin
        r_cycles <= r_cycles + CW'(1);
      end
    end
  end

  assign cycles = r_cycles;
`endif

endmodule
